// File: rtl/sha256_message_parse.sv
// SHA-256 padding stripper: turns padded 512-bit blocks back into message data blocks,
// recovers the bit length L and flags padding/length inconsistencies.
module sha256_message_parse #(
    parameter int CNT_W = 55
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         sync_rst,
    input  logic [511:0] data_in,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [511:0] data_out,
    output logic         data_out_last,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic [63:0]  size_out,
    output logic         size_err,
    output logic         size_valid,
    input  logic         size_ready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EMIT_A = 3'd3,
        ST_EMIT_B = 3'd4,
        ST_SIZE   = 3'd5
    } state_t;

    localparam logic [511:0]     ONES    = {512{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Keep the top nbits of a block, zero the rest.
    function automatic logic [511:0] keep_top(input logic [8:0] nbits);
        keep_top = ~(ONES >> nbits);
    endfunction

    // Bits strictly below the marker position 511-r.
    function automatic logic [511:0] below_marker(input logic [8:0] r);
        below_marker = ONES >> ({1'b0, r} + 10'd1);
    endfunction

    // Block count, marker and zero-fill consistency of the received padding.
    function automatic logic pad_error(input logic [511:0]   hold_blk,
                                       input logic           hold_vld,
                                       input logic [511:0]   last_blk,
                                       input logic [CNT_W-1:0] cnt);
        logic [63:0]  len;
        logic [8:0]   r;
        logic [64:0]  n_exp;
        logic [64:0]  n_got;
        logic [511:0] below;
        logic         mark_ok;
        logic         tail_ok;
        len   = last_blk[63:0];
        r     = len[8:0];
        n_exp = ({1'b0, len} + 65'd576) >> 9;
        n_got = {{(65-CNT_W){1'b0}}, cnt} + 65'd1;
        below = below_marker(r);
        if (r <= 9'd447) begin
            mark_ok = last_blk[9'd511 - r];
            tail_ok = ((last_blk[511:64] & below[511:64]) == 448'd0);
        end else begin
            mark_ok = hold_vld & hold_blk[9'd511 - r];
            tail_ok = ((hold_blk & below) == 512'd0) && (last_blk[511:64] == 448'd0);
        end
        pad_error = (n_got != n_exp) | ~mark_ok | ~tail_ok;
    endfunction

    state_t             state_r, state_s;
    logic [511:0]       buf_r;
    logic               buf_vld_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [511:0]       last_r;
    logic [63:0]        len_r;
    logic               err_r;
    logic [511:0]       dout_r;
    logic               dout_last_r;
    logic               dout_vld_r;
    logic [63:0]        size_r;
    logic               size_err_r;
    logic               size_vld_r;

    logic               in_ready_s;
    logic               take_buf_s;
    logic               take_last_s;
    logic               emit_s;
    logic [511:0]       emit_data_s;
    logic               emit_last_s;
    logic               decode_s;
    logic               size_load_s;
    logic               size_done_s;
    logic               slot_free_s;
    logic [8:0]         rem_s;
    logic [8:0]         dec_rem_s;
    logic               b_need_s;
    logic               dec_b_need_s;

    assign slot_free_s  = ~dout_vld_r | data_out_ready;
    assign rem_s        = len_r[8:0];
    assign dec_rem_s    = last_r[8:0];
    assign b_need_s     = (rem_s != 9'd0) && (rem_s <= 9'd447);
    assign dec_b_need_s = (dec_rem_s != 9'd0) && (dec_rem_s <= 9'd447);

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s     = state_r;
        in_ready_s  = 1'b0;
        take_buf_s  = 1'b0;
        take_last_s = 1'b0;
        emit_s      = 1'b0;
        emit_data_s = 512'd0;
        emit_last_s = 1'b0;
        decode_s    = 1'b0;
        size_load_s = 1'b0;
        size_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = en;
                if (in_ready_s && data_in_valid) begin
                    if (data_in_last) begin
                        take_last_s = 1'b1;
                        state_s     = ST_DECODE;
                    end else begin
                        take_buf_s = 1'b1;
                        state_s    = ST_HOLD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                in_ready_s = en & slot_free_s;
                if (in_ready_s && data_in_valid) begin
                    if (data_in_last) begin
                        take_last_s = 1'b1;
                        state_s     = ST_DECODE;
                    end else begin
                        take_buf_s  = 1'b1;
                        emit_s      = 1'b1;
                        emit_data_s = buf_r;
                        emit_last_s = 1'b0;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DECODE: begin
                if (en) begin
                    decode_s = 1'b1;
                    if (buf_vld_r && (last_r[63:0] != 64'd0)) begin
                        state_s = ST_EMIT_A;
                    end else if (dec_b_need_s) begin
                        state_s = ST_EMIT_B;
                    end else begin
                        state_s = ST_SIZE;
                    end
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_EMIT_A: begin
                if (en && slot_free_s) begin
                    emit_s = 1'b1;
                    // With r>=448 the held block is the final data block.
                    if (rem_s >= 9'd448) begin
                        emit_data_s = buf_r & keep_top(rem_s);
                        emit_last_s = 1'b1;
                    end else begin
                        emit_data_s = buf_r;
                        emit_last_s = (rem_s == 9'd0);
                    end
                    state_s = b_need_s ? ST_EMIT_B : ST_SIZE;
                end else begin
                    state_s = ST_EMIT_A;
                end
            end
            ST_EMIT_B: begin
                if (en && slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_data_s = last_r & keep_top(rem_s);
                    emit_last_s = 1'b1;
                    state_s     = ST_SIZE;
                end else begin
                    state_s = ST_EMIT_B;
                end
            end
            ST_SIZE: begin
                if (!en) begin
                    state_s = ST_SIZE;
                end else if (!size_vld_r) begin
                    size_load_s = 1'b1;
                end else if (size_ready) begin
                    size_done_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_SIZE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else if (sync_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Hold buffer, last block, block count and decoded length/error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_r     <= 512'd0;
            buf_vld_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            last_r    <= 512'd0;
            len_r     <= 64'd0;
            err_r     <= 1'b0;
        end else if (sync_rst) begin
            buf_r     <= 512'd0;
            buf_vld_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            last_r    <= 512'd0;
            len_r     <= 64'd0;
            err_r     <= 1'b0;
        end else if (en) begin
            if (take_buf_s) begin
                buf_r     <= data_in;
                buf_vld_r <= 1'b1;
                cnt_r     <= (state_r == ST_IDLE) ? CNT_ONE : cnt_r + CNT_ONE;
            end else if (size_done_s) begin
                buf_vld_r <= 1'b0;
                cnt_r     <= {CNT_W{1'b0}};
            end
            if (take_last_s) begin
                last_r <= data_in;
            end
            if (decode_s) begin
                len_r <= last_r[63:0];
                err_r <= pad_error(buf_r, buf_vld_r, last_r, cnt_r);
            end
        end
    end

    // Registered data and size output channels.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dout_r      <= 512'd0;
            dout_last_r <= 1'b0;
            dout_vld_r  <= 1'b0;
            size_r      <= 64'd0;
            size_err_r  <= 1'b0;
            size_vld_r  <= 1'b0;
        end else if (sync_rst) begin
            dout_r      <= 512'd0;
            dout_last_r <= 1'b0;
            dout_vld_r  <= 1'b0;
            size_r      <= 64'd0;
            size_err_r  <= 1'b0;
            size_vld_r  <= 1'b0;
        end else if (en) begin
            if (emit_s) begin
                dout_r      <= emit_data_s;
                dout_last_r <= emit_last_s;
                dout_vld_r  <= 1'b1;
            end else if (dout_vld_r && data_out_ready) begin
                dout_vld_r <= 1'b0;
            end
            if (size_load_s) begin
                size_r     <= len_r;
                size_err_r <= err_r;
                size_vld_r <= 1'b1;
            end else if (size_done_s) begin
                size_vld_r <= 1'b0;
            end
        end
    end

    assign data_in_ready  = in_ready_s;
    assign data_out       = dout_r;
    assign data_out_last  = dout_last_r;
    assign data_out_valid = dout_vld_r;
    assign size_out       = size_r;
    assign size_err       = size_err_r;
    assign size_valid     = size_vld_r;

endmodule

// File: tb/tb_sha256_message_parse.sv
// Bench for sha256_message_parse: messages are padded by a bit-stream reference model,
// fed through the parser and the recovered beats/size compared against the original message.
module tb_sha256_message_parse;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic         sync_rst;
    logic [511:0] data_in;
    logic         data_in_last;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [511:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;
    logic [63:0]  size_out;
    logic         size_err;
    logic         size_valid;
    logic         size_ready;

    sha256_message_parse #(.CNT_W(55)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .sync_rst       (sync_rst),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .size_out       (size_out),
        .size_err       (size_err),
        .size_valid     (size_valid),
        .size_ready     (size_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    bit           msg_q[$];
    logic [511:0] tx_blocks[$];
    logic [511:0] exp_data[$];
    bit           exp_last[$];
    logic [63:0]  exp_len;
    bit           exp_err;

    logic [511:0] got_data[$];
    bit           got_last[$];
    logic [63:0]  got_size[$];
    bit           got_err[$];

    // Record every completed handshake on the output channels.
    always @(negedge clk) begin
        if (nrst && en && !sync_rst) begin
            if (data_out_valid && data_out_ready) begin
                got_data.push_back(data_out);
                got_last.push_back(data_out_last);
            end
            if (size_valid && size_ready) begin
                got_size.push_back(size_out);
                got_err.push_back(size_err);
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            data_out_ready = 1'($urandom_range(0, 1));
            size_ready     = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic make_rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic make_abc_msg();
        logic [23:0] abc;
        abc = 24'h616263;
        msg_q.delete();
        for (int i = 23; i >= 0; i--) msg_q.push_back(abc[i]);
    endtask

    // Pad the message as a plain bit stream and slice it into blocks and expected beats.
    task automatic build_model();
        bit           p[$];
        int           len;
        int           nb;
        logic [63:0]  lv;
        logic [511:0] b;
        len = msg_q.size();
        lv  = 64'(len);
        p   = msg_q;
        p.push_back(1'b1);
        while ((p.size() % 512) != 448) p.push_back(1'b0);
        for (int i = 63; i >= 0; i--) p.push_back(lv[i]);
        tx_blocks.delete();
        for (int k = 0; k < p.size() / 512; k++) begin
            for (int i = 0; i < 512; i++) b[511-i] = p[k*512+i];
            tx_blocks.push_back(b);
        end
        exp_data.delete();
        exp_last.delete();
        nb = (len + 511) / 512;
        for (int k = 0; k < nb; k++) begin
            b = 512'd0;
            for (int i = 0; i < 512; i++)
                if (k*512 + i < len) b[511-i] = msg_q[k*512+i];
            exp_data.push_back(b);
            exp_last.push_back(k == nb - 1);
        end
        exp_len = lv;
        exp_err = 1'b0;
    endtask

    task automatic send_one(input logic [511:0] blk, input bit last);
        bit acc;
        acc = 1'b0;
        if (rand_rdy) repeat ($urandom_range(0, 2)) step();
        data_in       = blk;
        data_in_last  = last;
        data_in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = (data_in_ready === 1'b1);
            step();
        end
        chk("in_accept", 512'(acc), 512'd1);
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
    endtask

    task automatic send_all();
        for (int b = 0; b < tx_blocks.size(); b++)
            send_one(tx_blocks[b], b == tx_blocks.size() - 1);
    endtask

    task automatic finish_msg(input string tag, input int bbase, input int sbase);
        int t;
        t = 0;
        while (got_size.size() == sbase && t < 400) begin step(); t++; end
        t = 0;
        while (data_out_valid && t < 400) begin step(); t++; end
        chk({tag, "_nsize"}, 512'(got_size.size() - sbase), 512'd1);
        chk({tag, "_nbeats"}, 512'(got_data.size() - bbase), 512'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && bbase + i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[bbase+i], exp_data[i]);
            chk($sformatf("%s_last%0d", tag, i), 512'(got_last[bbase+i]), 512'(exp_last[i]));
        end
        if (got_size.size() > sbase) begin
            chk({tag, "_size"}, 512'(got_size[sbase]), 512'(exp_len));
            chk({tag, "_err"}, 512'(got_err[sbase]), 512'(exp_err));
        end
    endtask

    task automatic run_msg(input string tag);
        int bbase;
        int sbase;
        bbase = got_data.size();
        sbase = got_size.size();
        send_all();
        finish_msg(tag, bbase, sbase);
    endtask

    task automatic run_abc_latency(input string tag);
        int bbase;
        int sbase;
        make_abc_msg();
        build_model();
        bbase = got_data.size();
        sbase = got_size.size();
        send_all();
        chk({tag, "_lat0"}, 512'(data_out_valid), 512'd0);
        step();
        chk({tag, "_lat1"}, 512'(data_out_valid), 512'd0);
        step();
        chk({tag, "_lat2"}, 512'(data_out_valid), 512'd1);
        finish_msg(tag, bbase, sbase);
    endtask

    initial begin
        int           lens[8];
        int           bbase;
        int           sbase;
        logic [511:0] b;
        nrst           = 1'b0;
        en             = 1'b1;
        sync_rst       = 1'b0;
        data_in        = 512'd0;
        data_in_last   = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        size_ready     = 1'b1;
        repeat (2) step();
        chk("rst_in_ready", 512'(data_in_ready), 512'd1);
        chk("rst_dout_valid", 512'(data_out_valid), 512'd0);
        chk("rst_dout", data_out, 512'd0);
        chk("rst_dout_last", 512'(data_out_last), 512'd0);
        chk("rst_size_valid", 512'(size_valid), 512'd0);
        chk("rst_size", 512'(size_out), 512'd0);
        chk("rst_size_err", 512'(size_err), 512'd0);
        nrst = 1'b1;
        step();

        run_abc_latency("abc");

        make_rand_msg(448);  build_model(); run_msg("L448");
        make_rand_msg(512);  build_model(); run_msg("L512");
        make_rand_msg(0);    build_model(); run_msg("L0");

        make_abc_msg(); build_model();
        b = tx_blocks[0]; b[487] = 1'b0; tx_blocks[0] = b;
        exp_err = 1'b1;
        run_msg("abc_nomark");

        make_abc_msg(); build_model();
        b = tx_blocks[0]; b[63:0] = 64'h218; tx_blocks[0] = b;
        exp_err = 1'b1;
        exp_len = 64'h218;
        run_msg("abc_badlen");

        rand_rdy = 1'b1;
        lens = '{447, 448, 511, 512, 513, 959, 960, 1};
        foreach (lens[i]) begin
            make_rand_msg(lens[i]); build_model(); run_msg($sformatf("bnd%0d", lens[i]));
        end
        for (int k = 0; k < 6; k++) begin
            make_rand_msg(int'($urandom_range(1, 1600))); build_model();
            run_msg($sformatf("rnd%0d", k));
        end
        rand_rdy       = 1'b0;
        data_out_ready = 1'b1;
        size_ready     = 1'b1;
        repeat (3) step();

        // Stall, freeze and reset in the middle of a three-block message.
        make_rand_msg(1200); build_model();
        bbase = got_data.size();
        sbase = got_size.size();
        data_out_ready = 1'b0;
        send_one(tx_blocks[0], 1'b0);
        send_one(tx_blocks[1], 1'b0);
        data_in       = tx_blocks[2];
        data_in_last  = 1'b1;
        data_in_valid = 1'b1;
        repeat (5) step();
        chk("stall_dout_valid", 512'(data_out_valid), 512'd1);
        chk("stall_in_ready", 512'(data_in_ready), 512'd0);
        chk("stall_dout", data_out, tx_blocks[0]);
        data_out_ready = 1'b1;
        en             = 1'b0;
        repeat (3) step();
        chk("frz_dout_valid", 512'(data_out_valid), 512'd1);
        chk("frz_in_ready", 512'(data_in_ready), 512'd0);
        chk("frz_nbeats", 512'(got_data.size() - bbase), 512'd0);
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        en            = 1'b1;
        step();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        chk("srst_dout_valid", 512'(data_out_valid), 512'd0);
        chk("srst_size_valid", 512'(size_valid), 512'd0);
        chk("srst_in_ready", 512'(data_in_ready), 512'd1);
        chk("srst_nbeats", 512'(got_data.size() - bbase), 512'd1);
        if (got_data.size() > bbase) begin
            chk("srst_beat0", got_data[bbase], tx_blocks[0]);
            chk("srst_last0", 512'(got_last[bbase]), 512'd0);
        end
        repeat (10) step();
        chk("srst_nsize", 512'(got_size.size() - sbase), 512'd0);

        run_abc_latency("abc_again");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
